des_rd_resp_gen: RTL and testbench

// Responder side of the des_worker read-request interface. Accepts one read request
// (addr/size/len plus the parent task), fetches 64-byte lines from the tile memory port,
// and returns one response task per word with word index and last marking, which
// des_worker consumes as in_data/in_word_id. Sits between the RO worker stage and L1.

---
 rtl/des_rd_resp_gen.sv | 216 +++++++++++++++++++++
 tb/tb_des_rd_resp_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_rd_resp_gen.sv
// des_rd_resp_gen: responder side of the des_worker read-request interface.
// Takes one read request (byte address, word size, word count and the parent task),
// fetches the covering LINE_BYTES-wide lines from tile memory one at a time, and
// returns one response per word carrying the word index and an optional last flag.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_*                      request channel (valid/ready, addr, size, len, task,
//                              subtype, mark_last, cq_slot)
//   mem_ar* / mem_r*           line read channel (one read outstanding at a time)
//   resp_*                     response channel, one beat per word
module des_rd_resp_gen #(
  parameter int TILE_ID    = 0,
  parameter int LINE_BYTES = 64,
  parameter int TASK_W     = 32,
  parameter int SUBTYPE_W  = 4,
  parameter int CQ_SLOT_W  = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [2:0]              req_size,
  input  logic [7:0]              req_len,
  input  logic [TASK_W-1:0]       req_task,
  input  logic [SUBTYPE_W-1:0]    req_subtype,
  input  logic                    req_mark_last,
  input  logic [CQ_SLOT_W-1:0]    req_cq_slot,
  output logic                    mem_arvalid,
  input  logic                    mem_arready,
  output logic [31:0]             mem_araddr,
  input  logic                    mem_rvalid,
  output logic                    mem_rready,
  input  logic [8*LINE_BYTES-1:0] mem_rdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [TASK_W-1:0]       resp_task,
  output logic [SUBTYPE_W-1:0]    resp_subtype,
  output logic [63:0]             resp_data,
  output logic [7:0]              resp_word_id,
  output logic [CQ_SLOT_W-1:0]    resp_cq_slot,
  output logic                    resp_last
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;

  // Elaboration-time sanity checks on the parameters.
  if ((LINE_BYTES < 8) || ((LINE_BYTES & (LINE_BYTES - 1)) != 0)) begin : g_bad_line
    $error("LINE_BYTES must be a power of two of at least 8");
  end
  if (TILE_ID < 0) begin : g_bad_tile
    $error("TILE_ID must be non-negative");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_SEND} state_e;

  // Pick 2^size bytes starting at byte offset 'off' of a line, zero-extended.
  // Addresses are size-aligned and LINE_BYTES >= 8, so the word never straddles lines.
  function automatic logic [63:0] extract_word(input logic [LINE_W-1:0] line,
                                               input logic [OFF_W-1:0]  off,
                                               input logic [1:0]        size);
    logic [LINE_W-1:0] shifted;
    logic [63:0]       raw;
    shifted = line >> {off, 3'b000};
    raw     = shifted[63:0];
    case (size)
      2'd0:    return {56'd0, raw[7:0]};
      2'd1:    return {48'd0, raw[15:0]};
      2'd2:    return {32'd0, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  state_e                  state_q;
  logic [31:0]             cur_addr_q;
  logic [1:0]              size_q;
  logic [7:0]              len_q;
  logic [7:0]              word_id_q;
  logic                    mark_last_q;
  logic [TASK_W-1:0]       task_q;
  logic [SUBTYPE_W-1:0]    subtype_q;
  logic [CQ_SLOT_W-1:0]    cq_slot_q;
  logic [LINE_W-1:0]       line_q;
  logic                    req_ready_q;
  logic                    mem_arvalid_q;
  logic [31:0]             mem_araddr_q;
  logic                    mem_rready_q;
  logic                    resp_valid_q;
  logic [63:0]             resp_data_q;
  logic                    resp_last_q;

  logic [1:0]              req_size_d;
  logic [31:0]             req_addr_d;
  logic [31:0]             cur_addr_d;
  logic [7:0]              word_id_d;
  logic                    line_cross_s;
  logic [63:0]             next_data_s;
  logic [63:0]             fill_data_s;

  // Request decode plus next-word address, line-crossing test and word extraction.
  always_comb begin
    req_size_d   = (req_size > 3'd3) ? 2'd3 : req_size[1:0];
    req_addr_d   = req_addr & (32'hFFFF_FFFF << req_size_d);
    cur_addr_d   = cur_addr_q + (32'd1 << size_q);
    word_id_d    = word_id_q + 8'd1;
    line_cross_s = (cur_addr_d[31:OFF_W] != cur_addr_q[31:OFF_W]);
    next_data_s  = extract_word(line_q, cur_addr_d[OFF_W-1:0], size_q);
    fill_data_s  = extract_word(mem_rdata, cur_addr_q[OFF_W-1:0], size_q);
  end

  // Transfer FSM; every output is a register so handshakes see stable values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= 32'd0;
      size_q        <= 2'd0;
      len_q         <= 8'd0;
      word_id_q     <= 8'd0;
      mark_last_q   <= 1'b0;
      task_q        <= '0;
      subtype_q     <= '0;
      cq_slot_q     <= '0;
      line_q        <= '0;
      req_ready_q   <= 1'b1;
      mem_arvalid_q <= 1'b0;
      mem_araddr_q  <= 32'd0;
      mem_rready_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 64'd0;
      resp_last_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cur_addr_q    <= req_addr_d;
            size_q        <= req_size_d;
            len_q         <= req_len;
            word_id_q     <= 8'd0;
            mark_last_q   <= req_mark_last;
            task_q        <= req_task;
            subtype_q     <= req_subtype;
            cq_slot_q     <= req_cq_slot;
            req_ready_q   <= 1'b0;
            mem_arvalid_q <= 1'b1;
            mem_araddr_q  <= {req_addr_d[31:OFF_W], {OFF_W{1'b0}}};
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_arready) begin
            mem_arvalid_q <= 1'b0;
            mem_rready_q  <= 1'b1;
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The first word comes straight off the incoming line to save a cycle.
          if (mem_rvalid) begin
            line_q       <= mem_rdata;
            mem_rready_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= fill_data_s;
            resp_last_q  <= mark_last_q & (word_id_q == len_q);
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (resp_ready) begin
            if (word_id_q == len_q) begin
              resp_valid_q <= 1'b0;
              resp_last_q  <= 1'b0;
              req_ready_q  <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              word_id_q  <= word_id_d;
              cur_addr_q <= cur_addr_d;
              if (line_cross_s) begin
                resp_valid_q  <= 1'b0;
                resp_last_q   <= 1'b0;
                mem_arvalid_q <= 1'b1;
                mem_araddr_q  <= {cur_addr_d[31:OFF_W], {OFF_W{1'b0}}};
                state_q       <= ST_ISSUE;
              end else begin
                resp_data_q <= next_data_s;
                resp_last_q <= mark_last_q & (word_id_d == len_q);
              end
            end
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          req_ready_q   <= 1'b1;
          mem_arvalid_q <= 1'b0;
          mem_rready_q  <= 1'b0;
          resp_valid_q  <= 1'b0;
          resp_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_arvalid  = mem_arvalid_q;
  assign mem_araddr   = mem_araddr_q;
  assign mem_rready   = mem_rready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_task    = task_q;
  assign resp_subtype = subtype_q;
  assign resp_data    = resp_data_q;
  assign resp_word_id = word_id_q;
  assign resp_cq_slot = cq_slot_q;
  assign resp_last    = resp_last_q;

endmodule

// File: tb/tb_des_rd_resp_gen.sv
// Scoreboard bench for des_rd_resp_gen: expected line reads and response words are
// queued when a request is driven, a memory responder and a response consumer pop
// and compare them as the design produces traffic.
module tb_des_rd_resp_gen;

  logic         clk;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [2:0]   req_size;
  logic [7:0]   req_len;
  logic [31:0]  req_task;
  logic [3:0]   req_subtype;
  logic         req_mark_last;
  logic [5:0]   req_cq_slot;
  logic         mem_arvalid;
  logic         mem_arready;
  logic [31:0]  mem_araddr;
  logic         mem_rvalid;
  logic         mem_rready;
  logic [511:0] mem_rdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_task;
  logic [3:0]   resp_subtype;
  logic [63:0]  resp_data;
  logic [7:0]   resp_word_id;
  logic [5:0]   resp_cq_slot;
  logic         resp_last;

  des_rd_resp_gen dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_len(req_len), .req_task(req_task),
    .req_subtype(req_subtype), .req_mark_last(req_mark_last), .req_cq_slot(req_cq_slot),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_task(resp_task),
    .resp_subtype(resp_subtype), .resp_data(resp_data), .resp_word_id(resp_word_id),
    .resp_cq_slot(resp_cq_slot), .resp_last(resp_last)
  );

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic        last;
    logic [31:0] tsk;
    logic [3:0]  st;
    logic [5:0]  cq;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] line_exp[$];
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          ar_delay  = 0;
  int          r_delay   = 0;
  int          stall_word = -1;
  int          stall_left = 0;
  int          stall_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory content: a simple function of the byte address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd7) + a[15:8] + a[31:24] + 8'h3C;
  endfunction

  function automatic logic [511:0] make_line(input logic [31:0] la);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = mem_byte(la + 32'(k));
    return l;
  endfunction

  task automatic push_expect(input logic [31:0] addr, input logic [2:0] sz_raw,
                             input logic [7:0] len, input logic mark,
                             input logic [31:0] tsk, input logic [3:0] st, input logic [5:0] cq);
    int          sz;
    logic [31:0] al, a, la, prev;
    exp_t        e;
    sz   = (sz_raw > 3'd3) ? 3 : int'(sz_raw);
    al   = addr & ~((32'd1 << sz) - 32'd1);
    prev = 32'd0;
    for (int i = 0; i <= int'(len); i++) begin
      a  = al + (32'(i) << sz);
      la = a & ~32'd63;
      if (i == 0 || la != prev) line_exp.push_back(la);
      prev   = la;
      e.id   = 8'(i);
      e.data = 64'd0;
      for (int k = 0; k < (1 << sz); k++) e.data[8*k +: 8] = mem_byte(a + 32'(k));
      e.last = mark && (i == int'(len));
      e.tsk  = tsk;
      e.st   = st;
      e.cq   = cq;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req_ready"},  64'(req_ready), 64'd1);
    check_eq({tag, "_arvalid"},    64'(mem_arvalid), 64'd0);
    check_eq({tag, "_rready"},     64'(mem_rready), 64'd0);
    check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check_eq({tag, "_resp_last"},  64'(resp_last), 64'd0);
    check_eq({tag, "_word_id"},    64'(resp_word_id), 64'd0);
    check_eq({tag, "_data"},       resp_data, 64'd0);
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [2:0] sz,
                          input logic [7:0] len, input logic mark);
    int guard;
    @(negedge clk);
    req_addr      = addr;
    req_size      = sz;
    req_len       = len;
    req_mark_last = mark;
    req_task      = $urandom;
    req_subtype   = 4'($urandom_range(0, 15));
    req_cq_slot   = 6'($urandom_range(0, 63));
    req_valid     = 1'b1;
    guard = 0;
    while (!req_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check_eq("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    check_eq("prev_drained", 64'(exp_q.size()), 64'd0);
    push_expect(addr, sz, len, mark, req_task, req_subtype, req_cq_slot);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("ar_latency", 64'(mem_arvalid), 64'd1);
    check_eq("busy_not_ready", 64'(req_ready), 64'd0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && line_exp.size() == 0 && req_ready) && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("drain_words", 64'(exp_q.size()), 64'd0);
    check_eq("drain_lines", 64'(line_exp.size()), 64'd0);
    check_eq("idle_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic run(input logic [31:0] addr, input logic [2:0] sz,
                     input logic [7:0] len, input logic mark);
    send_req(addr, sz, len, mark);
    wait_idle();
  endtask

  // Memory responder: one line read at a time with programmable delays.
  initial begin
    logic [31:0] a;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(negedge clk);
      if (rstn && mem_arvalid) begin
        a = mem_araddr;
        if (line_exp.size() == 0) check_eq("extra_line_rd", 64'(a), 64'hFFFF_FFFF_FFFF_FFFF);
        else check_eq("line_addr", 64'(a), 64'(line_exp.pop_front()));
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk);
          check_eq("ar_hold", 64'(mem_arvalid), 64'd1);
        end
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        check_eq("ar_drop", 64'(mem_arvalid), 64'd0);
        for (int i = 0; i < r_delay; i++) @(negedge clk);
        check_eq("rready", 64'(mem_rready), 64'd1);
        check_eq("no_early_resp", 64'(resp_valid), 64'd0);
        mem_rdata  = make_line(a);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("rv_latency", 64'(resp_valid), 64'd1);
      end
    end
  end

  // Response consumer: applies back-pressure on request, compares every visible beat.
  initial begin
    exp_t e;
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        resp_ready = 1'b1;
      end else begin
        if (resp_valid && stall_done == 0 && int'(resp_word_id) == stall_word) begin
          stall_left = 5;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          resp_ready = 1'b0;
          stall_left--;
        end else begin
          resp_ready = 1'b1;
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_resp", 64'(resp_word_id), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q[0];
            check_eq("resp_word_id", 64'(resp_word_id), 64'(e.id));
            check_eq("resp_data",    resp_data, e.data);
            check_eq("resp_last",    64'(resp_last), 64'(e.last));
            check_eq("resp_task",    64'(resp_task), 64'(e.tsk));
            check_eq("resp_subtype", 64'(resp_subtype), 64'(e.st));
            check_eq("resp_cq_slot", 64'(resp_cq_slot), 64'(e.cq));
            if (resp_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int guard;
    rstn          = 1'b0;
    req_valid     = 1'b0;
    req_addr      = 32'd0;
    req_size      = 3'd0;
    req_len       = 8'd0;
    req_task      = 32'd0;
    req_subtype   = 4'd0;
    req_mark_last = 1'b0;
    req_cq_slot   = 6'd0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rstn = 1'b1;

    run(32'h0000_1000, 3'd3, 8'd0, 1'b1);          // single 8-byte word, last
    stall_word = 4; stall_done = 0;
    run(32'h0000_1038, 3'd2, 8'd7, 1'b1);          // line crossing + 5-cycle stall
    stall_word = -1;
    run(32'h0000_1038, 3'd2, 8'd7, 1'b0);          // same, last never set
    ar_delay = 3; r_delay = 10;
    run(32'h0000_3000, 3'd1, 8'd3, 1'b1);          // slow memory
    ar_delay = 0; r_delay = 0;
    run(32'h0000_1003, 3'd2, 8'd1, 1'b1);          // misaligned -> 0x1000
    run(32'h0000_1005, 3'd0, 8'd3, 1'b1);          // byte words zero-extended
    run(32'h0000_1009, 3'd5, 8'd1, 1'b1);          // size clamped to 3 -> 0x1008
    send_req(32'h0000_4000, 3'd3, 8'd0, 1'b1);     // back-to-back requests
    send_req(32'h0000_4100, 3'd3, 8'd1, 1'b1);
    wait_idle();
    run(32'hFFFF_FFF8, 3'd3, 8'd1, 1'b1);          // address wraps at 2^32
    run(32'h0000_5000, 3'd0, 8'd255, 1'b1);        // 256 words

    // Reset while stalled on word 3 of 8.
    stall_word = 3; stall_done = 0;
    send_req(32'h0000_2000, 3'd3, 8'd7, 1'b1);
    guard = 0;
    while (!(stall_left > 0 && resp_word_id == 8'd3) && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("stall_reached", 64'(resp_word_id), 64'd3);
    #1 rstn = 1'b0;
    #1 check_reset("mid_rst");
    exp_q.delete();
    line_exp.delete();
    stall_left = 0;
    stall_word = -1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run(32'h0000_2040, 3'd3, 8'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
